i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- I2C target (slave) that answers the existing I2C master on the shared scl/sda bus.
- Decodes START/STOP, matches a 7-bit device address, and takes an 8-bit register pointer (block address).
- Writes incoming data bytes into an internal register file, or returns register bytes on reads.
- Fully synchronous to the system clock. scl/sda are oversampled. No clock stretching.

Parameters:
- DEV_ADDR, 7'h69, 7-bit bus address this target responds to.
- DEPTH, 256, number of 8-bit registers; pointer wraps modulo DEPTH (power of two, 2..256).
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in.

Ports:
- clk  in  1  system clock; must run at least 8x the SCL frequency.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  bus SCL level (resolved wired-AND).
- sda_in  in  1  bus SDA level (resolved wired-AND).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- busy  out  1  high from an address-matched START until STOP or NACK-terminated release.
- wr_strobe  out  1  one-cycle pulse when a data byte is committed to the register file.
- wr_addr  out  8  register index of the committed byte (valid with wr_strobe).
- wr_data  out  8  committed byte (valid with wr_strobe).
- host_raddr  in  8  local read port address.
- host_rdata  out  8  registered contents at host_raddr; 1-cycle latency.

Behaviour:
- Reset values:
  - sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, host_rdata=0.
  - All registers = 8'h00. Pointer = 0. FSM in IDLE.
  - Reset mid-transfer releases SDA on the next edge.
- Input conditioning:
  - SYNC_STAGES flops, then a 1-flop edge detector.
  - Bus events are acted on 3 clk after the pin changes.
- Bus events:
  - START (incl. repeated START) = sda falls while scl high.
  - STOP = sda rises while scl high.
  - Both override any state. START goes to ADDR with bit_cnt=0.
  - STOP goes to IDLE, sda_oe=0, busy=0.
- Timing:
  - Sample SDA on the synchronized scl rising edge.
  - Update sda_oe on the synchronized scl falling edge. This guarantees SDA is stable during SCL high.
- FSM states and transitions:
  - IDLE: waits for START.
  - ADDR: shift 8 bits MSB first.
    - Addr[7:1]==DEV_ADDR → ADDR_ACK; busy=1.
    - Otherwise → IDLE (no ACK; ignore bus until next START).
  - ADDR_ACK: drive sda_oe=1 for one SCL period.
    - rw=0 → REG.
    - rw=1 → RDATA: load shift reg from regs[ptr]; first bit driven on the ACK-ending falling edge.
  - REG: shift 8 bits → ptr = byte mod DEPTH → REG_ACK (ACK) → WDATA.
  - WDATA: shift 8 bits → WDATA_ACK.
    - Commit regs[ptr]=byte and pulse wr_strobe with wr_addr=ptr, wr_data=byte, on the 8th rising edge.
    - ACK, then ptr=ptr+1 mod DEPTH and return to WDATA for a burst.
  - RDATA: drive bit as sda_oe=~bit, 8 bits, then release for MACK.
  - MACK: sample master ACK on the rising edge.
    - 0 → ptr++, reload, RDATA.
    - 1 (NACK) → WAIT_STOP: SDA released, busy stays 1 until STOP or START.
- Register pointer:
  - Random read = write pointer (addr+W, reg), then repeated START, then addr+R.
  - Pointer persists across transactions; a read with no pointer phase starts at the current ptr.
- Pointer wrap-around: ptr=DEPTH-1 followed by increment → 0.
- host_raddr reads are independent of the bus. If host_raddr equals the address being committed in the same cycle, host_rdata returns the new value on the next cycle (write-first).
- Simultaneous edges: a START/STOP detection in the same cycle as an scl edge takes priority.
- Glitch/illegal: a STOP during any ACK phase releases SDA immediately. No error flag.

Decomposition:
- Package i2c_pkg:
  - State enum (IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT_STOP).
  - I2C_RW_WRITE=0, I2C_RW_READ=1.
  - Byte width constant 8.
- Sub-module i2c_bus_sync: synchronizer plus edge detector. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
- FSM and register file live in i2c_target_regs.

Test Plan:
- Write: with the existing master, write addr=7'h69, block_addr=8'h8D, data=8'h95 → three ACKs seen by master; wr_strobe once with wr_addr=8'h8D, wr_data=8'h95; host_raddr=8'h8D → host_rdata=8'h95.
- Read back: random read of 8'h8D → master data_out=8'h95; sda_oe never asserted while scl high except ACK/data-low bits; busy drops after STOP.
- Address mismatch: addr=7'h12 write → no ACK (master ack error), sda_oe stays 0 throughout, no wr_strobe, busy stays 0.
- Burst + wrap (DEPTH=256): pointer 8'hFE, data 8'h11, 8'h22, 8'h33 → regs[FE]=11, regs[FF]=22, regs[00]=33; three wr_strobe pulses.
- Read NACK + repeated START: 2-byte read from 8'h8D, master NACKs 2nd byte → sda_oe released; a new START within WAIT_STOP re-enters ADDR correctly.
- Reset mid-read: assert reset while driving a 0 data bit → sda_oe=0 on the next clk; all regs read 8'h00 afterward.

Source files
------------

// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

    localparam int   I2C_BYTE_W   = 8;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        REG       = 4'd3,
        REG_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        MACK      = 4'd8,
        WAIT_STOP = 4'd9
    } i2c_state_e;

endpackage

// File: rtl/i2c_target_regs_bus_sync.sv
// Synchronizes scl/sda into the clk domain and flags SCL edges and START/STOP.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;

    // Synchronizer chains plus one history flop; idle bus resets high so no false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q[0] <= scl_in;
            sda_sync_q[0] <= sda_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync_q[i] <= scl_sync_q[i-1];
                sda_sync_q[i] <= sda_sync_q[i-1];
            end
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register pointer and a DEPTH x 8 register file.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h69,
    parameter int         DEPTH       = 256,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] host_raddr,
    output logic [7:0] host_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .start_det(start_det_s),
        .stop_det (stop_det_s),
        .sda_s    (sda_s)
    );

    i2c_state_e               state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0]    shift_q, shift_d;
    logic [AW-1:0]            ptr_q, ptr_d;
    logic                     rw_q, rw_d;
    logic                     ack_on_q, ack_on_d;
    logic                     sda_oe_q, sda_oe_d;
    logic                     busy_q, busy_d;
    logic                     wr_strobe_q, wr_strobe_d;
    logic [7:0]               wr_addr_q, wr_addr_d;
    logic [7:0]               wr_data_q, wr_data_d;
    logic [7:0]               host_rdata_q, host_rdata_d;
    logic [I2C_BYTE_W-1:0]    regs_q [DEPTH];

    logic [I2C_BYTE_W-1:0]    shift_in_s;
    logic [AW-1:0]            ptr_inc_s;
    logic [I2C_BYTE_W-1:0]    rd_byte_s;

    assign shift_in_s = {shift_q[6:0], sda_s};
    assign ptr_inc_s  = ptr_q + AW'(1);
    assign rd_byte_s  = regs_q[ptr_q];

    // Bus protocol FSM; START/STOP outrank any SCL edge seen in the same cycle.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        ack_on_d    = ack_on_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (start_det_s) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            ack_on_d  = 1'b0;
        end else if (stop_det_s) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            ack_on_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, WDATA: begin
                    if (scl_rise_s) begin
                        shift_d   = shift_in_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                if (shift_in_s[7:1] == DEV_ADDR) begin
                                    state_d = ADDR_ACK;
                                    busy_d  = 1'b1;
                                    rw_d    = shift_in_s[0];
                                end else begin
                                    state_d = IDLE;
                                end
                            end else if (state_q == REG) begin
                                ptr_d   = shift_in_s[AW-1:0];
                                state_d = REG_ACK;
                            end else begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = 8'(ptr_q);
                                wr_data_d   = shift_in_s;
                                state_d     = WDATA_ACK;
                            end
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                // First falling edge starts the ACK, the second one ends it.
                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_fall_s) begin
                        if (!ack_on_q) begin
                            sda_oe_d = 1'b1;
                            ack_on_d = 1'b1;
                        end else begin
                            ack_on_d  = 1'b0;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            case (state_q)
                                ADDR_ACK: begin
                                    if (rw_q == I2C_RW_READ) begin
                                        state_d  = RDATA;
                                        shift_d  = {rd_byte_s[6:0], 1'b0};
                                        sda_oe_d = ~rd_byte_s[7];
                                    end else begin
                                        state_d = REG;
                                    end
                                end
                                REG_ACK:   state_d = WDATA;
                                WDATA_ACK: begin
                                    ptr_d   = ptr_inc_s;
                                    state_d = WDATA;
                                end
                                default:   state_d = IDLE;
                            endcase
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                RDATA: begin
                    if (scl_fall_s) begin
                        sda_oe_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end else if (scl_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = (bit_cnt_q == 3'd7) ? MACK : RDATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                MACK: begin
                    if (scl_fall_s) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise_s) begin
                        if (!sda_s) begin
                            ptr_d     = ptr_inc_s;
                            shift_d   = regs_q[ptr_inc_s];
                            bit_cnt_d = 3'd0;
                            state_d   = RDATA;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                IDLE, WAIT_STOP: state_d = state_q;
                default:         state_d = IDLE;
            endcase
        end

        host_rdata_d = regs_q[host_raddr[AW-1:0]];
        if (wr_strobe_d && (wr_addr_d[AW-1:0] == host_raddr[AW-1:0])) begin
            host_rdata_d = wr_data_d;
        end else begin
            host_rdata_d = regs_q[host_raddr[AW-1:0]];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            ptr_q        <= '0;
            rw_q         <= I2C_RW_WRITE;
            ack_on_q     <= 1'b0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= 8'h00;
            wr_data_q    <= 8'h00;
            host_rdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            rw_q         <= rw_d;
            ack_on_q     <= ack_on_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Register file, written on the cycle the committed byte is strobed out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_strobe_d) begin
            regs_q[wr_addr_d[AW-1:0]] <= wr_data_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-master bench for i2c_target_regs against an array model of the register file.
module tb_i2c_target_regs;

    localparam int         Q   = 40;
    localparam logic [6:0] DEV = 7'h69;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m, sda_bus;
    logic       sda_oe, busy, wr_strobe;
    logic [7:0] wr_addr, wr_data, host_raddr, host_rdata;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_m),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .host_raddr(host_raddr),
        .host_rdata(host_rdata)
    );

    int         total = 0;
    int         bad   = 0;
    int         strobe_cnt = 0;
    int         oe_cycles  = 0;
    logic [7:0] hrd_at_strobe;
    logic [15:0] strobe_log [256];

    logic [7:0] model_regs [256];
    int         model_ptr;
    logic [7:0] wbuf [8];

    // Observe strobes and SDA drive away from the active clock edge.
    always @(negedge clk) begin
        if (sda_oe) oe_cycles++;
        if (wr_strobe) begin
            strobe_log[strobe_cnt % 256] = {wr_addr, wr_data};
            hrd_at_strobe = host_rdata;
            strobe_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SCL clock: SDA set mid-low, sampled mid-high; target drive checked across the high phase.
    task automatic bit_io(input logic b, input logic exp_oe, output logic rd);
        #Q sda_m = b;
        #Q scl_m = 1'b1;
        #Q rd = sda_bus;
        chk("oe_scl_high_mid", 32'(sda_oe), 32'(exp_oe));
        #Q chk("oe_scl_high_end", 32'(sda_oe), 32'(exp_oe));
        scl_m = 1'b0;
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic stop_c();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, output logic ack);
        logic rd;
        for (int i = 7; i >= 0; i--) bit_io(b[i], 1'b0, rd);
        bit_io(1'b1, exp_ack, rd);
        ack = ~rd;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic nack, output logic [7:0] got);
        logic rd;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, ~exp[i], rd);
            got[i] = rd;
        end
        bit_io(nack, 1'b0, rd);
    endtask

    task automatic host_check(input string tag, input logic [7:0] a);
        @(negedge clk);
        host_raddr = a;
        @(negedge clk);
        chk(tag, 32'(host_rdata), 32'(model_regs[a]));
    endtask

    task automatic wr_txn(input logic [7:0] p, input int n);
        logic ack;
        int   base;
        logic [7:0] exp_addr [8];
        base = strobe_cnt;
        start_c();
        send_byte({DEV, 1'b0}, 1'b1, ack);
        chk("wr_dev_ack", 32'(ack), 32'd1);
        chk("busy_after_match", 32'(busy), 32'd1);
        send_byte(p, 1'b1, ack);
        chk("wr_reg_ack", 32'(ack), 32'd1);
        model_ptr = int'(p);
        for (int k = 0; k < n; k++) begin
            send_byte(wbuf[k], 1'b1, ack);
            chk("wr_data_ack", 32'(ack), 32'd1);
            model_regs[model_ptr] = wbuf[k];
            exp_addr[k] = 8'(model_ptr);
            model_ptr = (model_ptr + 1) % 256;
        end
        stop_c();
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("wr_strobe_count", 32'(strobe_cnt - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            chk("wr_addr_out", 32'(strobe_log[(base + k) % 256][15:8]), 32'(exp_addr[k]));
            chk("wr_data_out", 32'(strobe_log[(base + k) % 256][7:0]), 32'(wbuf[k]));
            host_check("host_after_write", exp_addr[k]);
        end
    endtask

    task automatic rd_txn(input logic set_ptr, input logic [7:0] p, input int n);
        logic ack;
        logic [7:0] got;
        if (set_ptr) begin
            start_c();
            send_byte({DEV, 1'b0}, 1'b1, ack);
            chk("rd_ptr_dev_ack", 32'(ack), 32'd1);
            send_byte(p, 1'b1, ack);
            chk("rd_ptr_reg_ack", 32'(ack), 32'd1);
            model_ptr = int'(p);
        end
        start_c();
        send_byte({DEV, 1'b1}, 1'b1, ack);
        chk("rd_dev_ack", 32'(ack), 32'd1);
        for (int k = 0; k < n; k++) begin
            recv_byte(model_regs[model_ptr], (k == n - 1), got);
            chk("rd_data", 32'(got), 32'(model_regs[model_ptr]));
            if (k < n - 1) model_ptr = (model_ptr + 1) % 256;
        end
        stop_c();
        chk("busy_after_rd_stop", 32'(busy), 32'd0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] got;
        int         base_oe, base_st;

        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_raddr = 8'h00;
        for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        #40;
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        reset = 1'b0;
        #40;

        // Single write with the host port watching the same address.
        host_raddr = 8'h8D;
        wbuf[0] = 8'h95;
        wr_txn(8'h8D, 1);
        chk("write_first_forward", 32'(hrd_at_strobe), 32'h95);

        rd_txn(1'b1, 8'h8D, 1);

        // Non-matching address: no ACK, no drive, no write, never busy.
        base_oe = oe_cycles; base_st = strobe_cnt;
        start_c();
        send_byte({7'h12, 1'b0}, 1'b0, ack);
        chk("mismatch_ack", 32'(ack), 32'd0);
        chk("mismatch_busy", 32'(busy), 32'd0);
        send_byte(8'h55, 1'b0, ack);
        chk("mismatch_ack2", 32'(ack), 32'd0);
        stop_c();
        chk("mismatch_oe_cycles", 32'(oe_cycles - base_oe), 32'd0);
        chk("mismatch_strobes", 32'(strobe_cnt - base_st), 32'd0);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        wr_txn(8'hFE, 3);
        host_check("wrap_fe", 8'hFE);
        host_check("wrap_ff", 8'hFF);
        host_check("wrap_00", 8'h00);

        // Two-byte read NACKed, then a repeated START straight out of WAIT_STOP.
        start_c();
        send_byte({DEV, 1'b0}, 1'b1, ack);
        send_byte(8'h8D, 1'b1, ack);
        model_ptr = 'h8D;
        start_c();
        send_byte({DEV, 1'b1}, 1'b1, ack);
        chk("nack_rd_dev_ack", 32'(ack), 32'd1);
        recv_byte(model_regs[8'h8D], 1'b0, got);
        chk("nack_rd_b0", 32'(got), 32'(model_regs[8'h8D]));
        recv_byte(model_regs[8'h8E], 1'b1, got);
        chk("nack_rd_b1", 32'(got), 32'(model_regs[8'h8E]));
        model_ptr = 'h8E;
        #(2 * Q);
        chk("nack_released", 32'(sda_oe), 32'd0);
        chk("nack_busy_held", 32'(busy), 32'd1);
        start_c();
        send_byte({DEV, 1'b0}, 1'b1, ack);
        chk("restart_dev_ack", 32'(ack), 32'd1);
        send_byte(8'h40, 1'b1, ack);
        send_byte(8'hA5, 1'b1, ack);
        chk("restart_data_ack", 32'(ack), 32'd1);
        model_regs[8'h40] = 8'hA5;
        model_ptr = 'h41;
        stop_c();
        host_check("restart_write", 8'h40);

        // Randomized transactions against the model.
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                int n;
                n = int'($urandom_range(1, 4));
                for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                wr_txn(8'($urandom), n);
            end else begin
                rd_txn(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(1, 3)));
            end
        end

        // Pointer-less read starts at the current pointer.
        rd_txn(1'b0, 8'h00, 2);

        // Reset while the target pulls SDA low for a data bit.
        wbuf[0] = 8'h3C;
        wr_txn(8'h20, 1);
        start_c();
        send_byte({DEV, 1'b0}, 1'b1, ack);
        send_byte(8'h20, 1'b1, ack);
        start_c();
        send_byte({DEV, 1'b1}, 1'b1, ack);
        #Q;
        chk("mid_read_driving", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        #6;
        chk("reset_releases_sda", 32'(sda_oe), 32'd0);
        #34;
        reset = 1'b0;
        sda_m = 1'b1;
        stop_c();
        for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        chk("post_reset_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 256; i++) host_check("post_reset_reg", 8'(i));
        rd_txn(1'b0, 8'h00, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
